// File: rtl/bus_device_port.sv
// rtl/bus_device_port.sv - memory-mapped bus device with four registers and a byte output FIFO
module bus_device_port #(
    parameter logic [3:0] REGION     = 4'b0111,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic [24:0] bus_addr,
    input  logic        bus_req,
    input  logic        bus__w,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    output logic        bus_data_oe,
    output logic        bus_ack,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        irq
);

    localparam int         PW      = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK, S_HOLD} state_t;

    state_t      r_state;
    logic        r_wait_drop;
    logic [1:0]  r_off;
    logic        r_write;
    logic [7:0]  r_wdata;
    logic [7:0]  r_dout;
    logic        r_oe;
    logic        r_ack;
    logic [7:0]  r_scratch;
    logic        r_irqen;
    logic        r_overflow;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [4:0]  r_count;

    logic        w_sel;
    logic        w_empty;
    logic        w_full;
    logic        w_push_req;
    logic        w_pop;
    logic        w_do_push;
    logic        w_overflow_set;
    logic [7:0]  w_rdata;
    logic        w_unused;

    assign w_unused       = &{1'b0, bus_addr[24], bus_addr[19:2]};
    assign w_sel          = bus_req && (bus_addr[23:20] == REGION);
    assign w_empty        = (r_count == 5'd0);
    assign w_full         = (r_count == DEPTH_C);
    assign w_pop          = !w_empty && out_ready;
    assign w_push_req     = (r_state == S_ACCESS) && r_write && (r_off == 2'd0);
    // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
    assign w_do_push      = w_push_req && (!w_full || w_pop);
    assign w_overflow_set = w_push_req && w_full && !w_pop;

    assign out_valid    = !w_empty;
    assign out_data     = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign irq          = r_irqen && (w_empty || r_overflow);
    assign bus_data_out = r_dout;
    assign bus_data_oe  = r_oe;
    assign bus_ack      = r_ack;

    always_comb begin
        w_rdata = 8'h00;
        case (r_off)
            2'd0: w_rdata = 8'h00;
            2'd1: w_rdata = {r_count, r_overflow, w_full, w_empty};
            2'd2: w_rdata = r_scratch;
            2'd3: w_rdata = {7'd0, r_irqen};
            default: w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_state     <= S_IDLE;
            r_wait_drop <= 1'b1;
            r_off       <= 2'd0;
            r_write     <= 1'b0;
            r_wdata     <= 8'h00;
            r_dout      <= 8'h00;
            r_oe        <= 1'b0;
            r_ack       <= 1'b0;
            r_scratch   <= 8'h00;
            r_irqen     <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // After reset a request that is still high must drop before it counts.
                    if (!bus_req) begin
                        r_wait_drop <= 1'b0;
                    end
                    if (w_sel && !r_wait_drop) begin
                        r_off   <= bus_addr[1:0];
                        r_write <= !bus__w;
                        r_wdata <= bus_data_in;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_state <= S_ACK;
                    r_ack   <= 1'b1;
                    r_oe    <= !r_write;
                    r_dout  <= r_write ? 8'h00 : w_rdata;
                    if (w_overflow_set) begin
                        r_overflow <= 1'b1;
                    end
                    if (r_write) begin
                        case (r_off)
                            2'd1: if (r_wdata[2]) r_overflow <= 1'b0;
                            2'd2: r_scratch <= r_wdata;
                            2'd3: r_irqen   <= r_wdata[0];
                            default: ;
                        endcase
                    end
                end
                S_ACK: begin
                    r_state <= S_HOLD;
                    r_ack   <= 1'b0;
                    r_oe    <= 1'b0;
                    r_dout  <= 8'h00;
                end
                S_HOLD: begin
                    if (!bus_req) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 5'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_bus_device_port.sv
// tb/tb_bus_device_port.sv - randomized self-checking bench for bus_device_port
module tb_bus_device_port;

    localparam logic [3:0] REGION = 4'b0111;
    localparam int         DEPTH  = 4;

    logic        clk = 1'b0;
    logic        _reset = 1'b0;
    logic [24:0] bus_addr = '0;
    logic        bus_req = 1'b0;
    logic        bus__w = 1'b1;
    logic [7:0]  bus_data_in = '0;
    logic [7:0]  bus_data_out;
    logic        bus_data_oe;
    logic        bus_ack;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q[$];
    logic       m_ovf;
    logic [7:0] m_scratch;
    logic       m_irqen;

    bus_device_port #(.REGION(REGION), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), ._reset(_reset), .bus_addr(bus_addr), .bus_req(bus_req),
        .bus__w(bus__w), .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
        .bus_data_oe(bus_data_oe), .bus_ack(bus_ack), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic void model_clear();
        q.delete();
        m_ovf = 1'b0;
        m_scratch = 8'h00;
        m_irqen = 1'b0;
    endfunction

    function automatic logic [7:0] exp_status();
        int n;
        n = q.size();
        return 8'(n * 8 + (m_ovf ? 4 : 0) + (n == DEPTH ? 2 : 0) + (n == 0 ? 1 : 0));
    endfunction

    function automatic logic exp_irq();
        return m_irqen && (q.size() == 0 || m_ovf);
    endfunction

    function automatic void model_write(input logic [1:0] off, input logic [7:0] d);
        case (off)
            2'd0: if (q.size() < DEPTH) q.push_back(d); else m_ovf = 1'b1;
            2'd1: if (d[2]) m_ovf = 1'b0;
            2'd2: m_scratch = d;
            default: m_irqen = d[0];
        endcase
    endfunction

    function automatic logic [7:0] model_read(input logic [1:0] off);
        case (off)
            2'd0: return 8'h00;
            2'd1: return exp_status();
            2'd2: return m_scratch;
            default: return {7'd0, m_irqen};
        endcase
    endfunction

    function automatic logic [24:0] mk_addr(input logic [1:0] off);
        logic [17:0] mid;
        logic        top;
        mid = 18'($urandom);
        top = 1'($urandom);
        return {top, REGION, mid, off};
    endfunction

    // One complete bus transaction, starting and ending just after a falling edge.
    task automatic do_access(input logic [24:0] addr, input logic wr, input logic [7:0] wdata,
                             input bit pop_mid, output logic [7:0] rdata);
        int lat;
        bit got;
        logic exp_v;
        exp_v = (q.size() != 0);
        bus_addr = addr; bus__w = ~wr; bus_data_in = wdata; bus_req = 1'b1;
        lat = 0; got = 0; rdata = 8'hxx;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                n_checks++;
                if (out_valid !== exp_v) begin
                    n_fail++; $display("FAIL pre_push_valid got=%b exp=%b", out_valid, exp_v);
                end
                if (pop_mid) out_ready = 1'b1;
            end
            if (lat == 2 && pop_mid) out_ready = 1'b0;
            if (bus_ack === 1'b1) begin
                got = 1;
                rdata = bus_data_out;
                n_checks++;
                if (bus_data_oe !== ~wr) begin
                    n_fail++; $display("FAIL ack_oe got=%b exp=%b", bus_data_oe, ~wr);
                end
            end else begin
                n_checks++;
                if (bus_data_oe !== 1'b0 || bus_data_out !== 8'h00) begin
                    n_fail++; $display("FAIL idle_drive oe=%b data=%h exp 0/00", bus_data_oe, bus_data_out);
                end
            end
        end
        n_checks++;
        if (!got || lat != 2) begin
            n_fail++; $display("FAIL ack_latency got=%0d exp=2 (ack seen=%0d)", lat, got);
        end
        bus_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus_ack !== 1'b0 || bus_data_oe !== 1'b0) begin
            n_fail++; $display("FAIL ack_pulse ack=%b oe=%b exp 0/0", bus_ack, bus_data_oe);
        end
        @(negedge clk);
    endtask

    task automatic reg_write(input logic [1:0] off, input logic [7:0] d);
        logic [7:0] rd;
        do_access(mk_addr(off), 1'b1, d, 0, rd);
        model_write(off, d);
    endtask

    task automatic reg_read(input logic [1:0] off, output logic [7:0] rd);
        do_access(mk_addr(off), 1'b0, 8'($urandom), 0, rd);
    endtask

    task automatic pop_one(output logic [7:0] d, output logic v);
        v = out_valid;
        d = out_data;
        if (v === 1'b1) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        _reset = 1'b0;
        bus_req = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus_ack, bus_data_oe, bus_data_out, out_valid, out_data, irq} !== 20'h0) begin
            n_fail++; $display("FAIL reset_outputs ack=%b oe=%b dout=%h v=%b od=%h irq=%b exp all 0",
                               bus_ack, bus_data_oe, bus_data_out, out_valid, out_data, irq);
        end
        _reset = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        reg_read(2'd1, rd);
        n_checks++;
        if (rd !== 8'h01) begin n_fail++; $display("FAIL reset_status got=%h exp=01", rd); end
        reg_read(2'd2, rd);
        n_checks++;
        if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_scratch got=%h exp=00", rd); end
        reg_read(2'd3, rd);
        n_checks++;
        if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_irqen got=%h exp=00", rd); end
    endtask

    task automatic test_scratch();
        logic [7:0] rd;
        do_access(25'h700002, 1'b1, 8'hA5, 0, rd);
        model_write(2'd2, 8'hA5);
        do_access(25'h700002, 1'b0, 8'h00, 0, rd);
        n_checks++;
        if (rd !== 8'hA5) begin n_fail++; $display("FAIL scratch_rw got=%h exp=a5", rd); end
        reg_read(2'd0, rd);
        n_checks++;
        if (rd !== 8'h00) begin n_fail++; $display("FAIL txdata_read got=%h exp=00", rd); end
    endtask

    task automatic test_unselected();
        logic [7:0] rd;
        bus_addr = 25'h300001; bus__w = 1'b1; bus_req = 1'b1;
        repeat (10) begin
            @(negedge clk);
            n_checks++;
            if (bus_ack !== 1'b0 || bus_data_oe !== 1'b0) begin
                n_fail++; $display("FAIL unselected ack=%b oe=%b exp 0/0", bus_ack, bus_data_oe);
            end
        end
        bus_req = 1'b0;
        repeat (2) @(negedge clk);
        reg_read(2'd2, rd);
        n_checks++;
        if (rd !== m_scratch) begin n_fail++; $display("FAIL after_unselected got=%h exp=%h", rd, m_scratch); end
    endtask

    task automatic test_overflow();
        logic [7:0] rd, d;
        logic v;
        for (int i = 1; i <= 5; i++) reg_write(2'd0, 8'(i));
        reg_read(2'd1, rd);
        n_checks++;
        if (rd !== 8'h26 || rd !== exp_status()) begin
            n_fail++; $display("FAIL overflow_status got=%h exp=26", rd);
        end
        for (int i = 1; i <= 4; i++) begin
            pop_one(d, v);
            n_checks++;
            if (v !== 1'b1 || d !== 8'(i)) begin
                n_fail++; $display("FAIL drain valid=%b data=%h exp 1/%h", v, d, 8'(i));
            end
            void'(q.pop_front());
        end
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            n_fail++; $display("FAIL drained valid=%b data=%h exp 0/00", out_valid, out_data);
        end
        reg_write(2'd1, 8'h04);
        reg_read(2'd1, rd);
        n_checks++;
        if (rd !== 8'h01) begin n_fail++; $display("FAIL ovf_clear got=%h exp=01", rd); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] rd, d;
        logic v;
        for (int i = 0; i < 4; i++) reg_write(2'd0, 8'h11 + 8'(i));
        do_access(mk_addr(2'd0), 1'b1, 8'h55, 1, rd);
        void'(q.pop_front());
        q.push_back(8'h55);
        reg_read(2'd1, rd);
        n_checks++;
        if (rd !== 8'h22) begin n_fail++; $display("FAIL full_push_pop_status got=%h exp=22", rd); end
        while (q.size() != 0) begin
            pop_one(d, v);
            n_checks++;
            if (v !== 1'b1 || d !== q[0]) begin
                n_fail++; $display("FAIL push_pop_order valid=%b data=%h exp 1/%h", v, d, q[0]);
            end
            void'(q.pop_front());
        end
    endtask

    task automatic test_irq();
        logic [7:0] rd, d;
        logic v;
        reg_write(2'd3, 8'h01);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_empty got=%b exp=1", irq); end
        reg_write(2'd3, 8'hFF);
        reg_read(2'd3, rd);
        n_checks++;
        if (rd !== 8'h01) begin n_fail++; $display("FAIL irqen_mask got=%h exp=01", rd); end
        reg_write(2'd0, 8'h77);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_one_byte got=%b exp=0", irq); end
        pop_one(d, v);
        void'(q.pop_front());
        n_checks++;
        if (irq !== 1'b1 || d !== 8'h77) begin
            n_fail++; $display("FAIL irq_popped irq=%b data=%h exp 1/77", irq, d);
        end
        for (int i = 0; i < 5; i++) reg_write(2'd0, 8'($urandom));
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_overflow got=%b exp=1", irq); end
        reg_write(2'd1, 8'h04);
        n_checks++;
        if (irq !== 1'b0 || irq !== exp_irq()) begin
            n_fail++; $display("FAIL irq_ovf_cleared got=%b exp=0", irq);
        end
        while (q.size() != 0) begin
            pop_one(d, v);
            void'(q.pop_front());
        end
        reg_write(2'd3, 8'h00);
    endtask

    task automatic test_random();
        logic [7:0] rd, d, e;
        logic v;
        int op;
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 8));
            case (op)
                0, 2, 4, 7: begin
                    d = 8'($urandom);
                    reg_write(op == 0 ? 2'd2 : op == 2 ? 2'd3 : op == 4 ? 2'd0 : 2'd1, d);
                end
                1, 3, 5, 8: begin
                    e = model_read(op == 1 ? 2'd2 : op == 3 ? 2'd3 : op == 5 ? 2'd1 : 2'd0);
                    reg_read(op == 1 ? 2'd2 : op == 3 ? 2'd3 : op == 5 ? 2'd1 : 2'd0, rd);
                    n_checks++;
                    if (rd !== e) begin n_fail++; $display("FAIL rand_read op=%0d got=%h exp=%h", op, rd, e); end
                end
                default: begin
                    e = (q.size() != 0) ? q[0] : 8'h00;
                    pop_one(d, v);
                    n_checks++;
                    if (v !== (q.size() != 0) || d !== e) begin
                        n_fail++; $display("FAIL rand_pop valid=%b data=%h exp %b/%h", v, d, q.size() != 0, e);
                    end
                    if (q.size() != 0) void'(q.pop_front());
                end
            endcase
            n_checks++;
            if (irq !== exp_irq() || out_valid !== (q.size() != 0)) begin
                n_fail++; $display("FAIL rand_state op=%0d irq=%b valid=%b exp %b/%b",
                                   op, irq, out_valid, exp_irq(), q.size() != 0);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        logic [7:0] rd;
        reg_write(2'd2, 8'h11);
        reg_write(2'd0, 8'h99);
        bus_addr = mk_addr(2'd2); bus__w = 1'b0; bus_data_in = 8'h3C; bus_req = 1'b1;
        @(negedge clk);
        _reset = 1'b0;
        #1;
        n_checks++;
        if (bus_ack !== 1'b0 || bus_data_oe !== 1'b0 || out_valid !== 1'b0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL async_reset ack=%b oe=%b valid=%b irq=%b exp all 0",
                               bus_ack, bus_data_oe, out_valid, irq);
        end
        @(negedge clk);
        _reset = 1'b1;
        model_clear();
        repeat (6) begin
            @(negedge clk);
            n_checks++;
            if (bus_ack !== 1'b0) begin n_fail++; $display("FAIL held_req_after_reset ack=%b exp=0", bus_ack); end
        end
        bus_req = 1'b0;
        repeat (2) @(negedge clk);
        reg_read(2'd2, rd);
        n_checks++;
        if (rd !== 8'h00) begin n_fail++; $display("FAIL scratch_after_abort got=%h exp=00", rd); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_scratch();
        test_unselected();
        test_overflow();
        test_full_push_pop();
        test_irq();
        test_random();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_device_port.md
BUS_DEVICE_PORT -- requirements
Module: bus_device_port

Interface
REQ-001 Parameter: REGION, 4'b0111, value of bus_addr[23:20] that selects this device.
REQ-002 Parameter: FIFO_DEPTH, 4, output FIFO entries (power of two, 2..16).
REQ-003 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port: _reset  in  1  asynchronous, active-low reset.
REQ-005 Port: bus_addr  in  25  system bus address from MAR.
REQ-006 Port: bus_req  in  1  initiator access request, held until bus_ack seen.
REQ-007 Port: bus__w  in  1  active-low write (0 = write, 1 = read), valid while bus_req high.
REQ-008 Port: bus_data_in  in  8  write data from initiator.
REQ-009 Port: bus_data_out  out  8  read data to initiator.
REQ-010 Port: bus_data_oe  out  1  drive enable for bus_data_out.
REQ-011 Port: bus_ack  out  1  access complete, one-cycle pulse.
REQ-012 Port: out_data  out  8  FIFO head byte to consumer.
REQ-013 Port: out_valid  out  1  FIFO non-empty.
REQ-014 Port: out_ready  in  1  consumer accepts head when high with out_valid.
REQ-015 Port: irq  out  1  interrupt request, level.

Function
REQ-016 Selection: access selected iff bus_req=1 and bus_addr[23:20]==REGION; register offset = bus_addr[1:0]; bits [19:2] and [24] ignored.
REQ-017 Register map: 0 TXDATA (W: push byte; R: 0x00); 1 STATUS (R: bit0 empty, bit1 full, bit2 overflow, bits[7:3] count; W: writing 1 to bit2 clears overflow, other bits ignored); 2 SCRATCH (R/W 8-bit); 3 IRQEN (R/W bit0 only, bits[7:1] read 0).
REQ-018 FSM states IDLE, ACCESS, ACK, HOLD.
REQ-019 IDLE -> ACCESS when selected access sampled; address, bus__w, bus_data_in captured on that edge.
REQ-020 ACCESS -> ACK unconditionally; write side-effect (register update or FIFO push) occurs on the ACCESS->ACK edge; read data registered on same edge.
REQ-021 ACK: bus_ack=1, bus_data_oe=1 for reads only, bus_data_out holds read data; ACK -> HOLD next cycle.
REQ-022 HOLD -> IDLE when bus_req=0; stays in HOLD while bus_req=1; no second access until bus_req has been low one cycle.
REQ-023 Latency: bus_ack asserts exactly 2 cycles after the edge sampling bus_req.
REQ-024 Unselected requests: FSM stays IDLE, bus_ack=0, bus_data_oe=0, no state change.
REQ-025 bus_data_oe=0 and bus_data_out=0x00 in all states except ACK-on-read.
REQ-026 FIFO: out_data = head; out_valid = (count != 0); pop when out_valid && out_ready.
REQ-027 Push when full with no same-cycle pop: byte discarded, overflow set (sticky).
REQ-028 Push and pop same cycle: both performed, count unchanged, including when full (no overflow).
REQ-029 Push into empty FIFO: out_valid rises the cycle after the push edge; a byte is never popped on the cycle it is pushed.
REQ-030 Read/write pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-031 Overflow clear and a same-cycle overflowing push cannot coincide (single access in flight); clear takes effect on the ACCESS->ACK edge.
REQ-032 irq = IRQEN[0] && (count==0 || overflow), combinational from registered state.

Reset
REQ-033 On _reset=0, immediately: FSM IDLE, bus_ack=0, bus_data_oe=0, bus_data_out=0x00, FIFO empty (pointers, count 0), out_valid=0, overflow=0, SCRATCH=0x00, IRQEN=0, irq=0.
REQ-034 Reset asserted mid-access aborts it without side-effect if before the ACCESS->ACK edge; after release FSM returns to IDLE and waits for bus_req=0 before accepting (treat as HOLD exit rule: a request still high at release is ignored until dropped).
REQ-035 out_data is 0x00 while FIFO empty after reset.

Verification
REQ-036 Write 0xA5 to addr 0x700002, then read 0x700002 -> bus_ack 2 cycles after each req; read returns 0xA5 with bus_data_oe=1 in ACK only.
REQ-037 Read addr 0x300001 (wrong region) held 10 cycles -> bus_ack never asserts, bus_data_oe stays 0.
REQ-038 out_ready=0; push 0x01..0x05 to offset 0 -> STATUS reads 0x26 (count 4, overflow, full); drain -> out_data 0x01,0x02,0x03,0x04 then out_valid=0.
REQ-039 FIFO full, out_ready=1, push 0x55 -> count stays 4, overflow stays 0, 0x55 emerges last.
REQ-040 IRQEN=1 with empty FIFO -> irq=1; push one byte -> irq=0; pop it -> irq=1; overflow then write STATUS 0x04 -> overflow and irq overflow term clear.
REQ-041 Assert _reset during ACCESS of a SCRATCH write of 0x3C with bus_req held high -> SCRATCH=0x00, no bus_ack until bus_req drops and re-asserts.
